rom_read_arbiter: RTL

//  Shares one asynchronous 4x4 ROM (2-bit address in, 4-bit data out, combinational) between
//  NUM_REQ requesters. Round-robin arbitration, one read in flight, registered response.

---
 rtl/rom_read_arbiter_if.sv | 28 ++
 rtl/rom_read_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter_if.sv
// Bus between the requesters / ROM and rom_read_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester and ROM side.
interface rom_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [ADDR_WIDTH-1:0]         rom_address;
  logic [DATA_WIDTH-1:0]         rom_data_in;
  logic                          rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ID_WIDTH-1:0]           rsp_id;

  modport slave (
    input  req, req_addr, rom_data_in,
    output gnt, rom_address, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req, req_addr, rom_data_in,
    input  gnt, rom_address, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM. It keeps one read in flight (IDLE->SETTLE->RESP).
// Defining ROM_RD_CNT_EN adds a 16-bit rd_count output that counts served reads.
module rom_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rom_read_arbiter_if.slave   bus
`ifdef ROM_RD_CNT_EN
  ,
  output logic [15:0]         rd_count
`endif
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [ID_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [ID_WIDTH-1:0]   id_reg, id_next;
  logic [ID_WIDTH-1:0]   rsp_id_reg, rsp_id_next;
  logic [ADDR_WIDTH-1:0] rom_address_reg, rom_address_next;
  logic [NUM_REQ-1:0]    gnt_reg, gnt_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;

  logic [NUM_REQ-1:0]    hit;
  logic [ID_WIDTH-1:0]   cand [NUM_REQ];
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_req;

  // cand[k] is the requester k places after rr_ptr, wrapping modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [ID_WIDTH:0] sum;
    assign sum      = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(gi);
    assign cand[gi] = (sum >= (ID_WIDTH+1)'(NUM_REQ))
                      ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_REQ))
                      : sum[ID_WIDTH-1:0];
    assign hit[gi]  = bus.req[cand[gi]];
  end

  // The lowest rotated offset with a pending request wins.
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner = cand[k];
      end
    end
  end

  assign any_req = |bus.req;

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    id_next          = id_reg;
    rom_address_next = rom_address_reg;
    gnt_next         = '0;
    rsp_valid_next   = 1'b0;
    rsp_data_next    = rsp_data_reg;
    rsp_id_next      = rsp_id_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          id_next          = winner;
          rom_address_next = bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
          state_next       = SETTLE;
        end
      end
      SETTLE: begin
        rsp_data_next    = bus.rom_data_in;
        rsp_valid_next   = 1'b1;
        gnt_next[id_reg] = 1'b1;
        rsp_id_next      = id_reg;
        state_next       = RESP;
      end
      RESP: begin
        rr_ptr_next = (id_reg == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      id_reg          <= '0;
      rom_address_reg <= '0;
      gnt_reg         <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_id_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      id_reg          <= id_next;
      rom_address_reg <= rom_address_next;
      gnt_reg         <= gnt_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_id_reg      <= rsp_id_next;
    end
  end

  assign bus.rom_address = rom_address_reg;
  assign bus.gnt         = gnt_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.rsp_id      = rsp_id_reg;

`ifdef ROM_RD_CNT_EN
  logic [15:0] rd_count_reg;

  // Count on the same edge that raises rsp_valid so the count already includes the visible pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_reg <= '0;
    end else if (rsp_valid_next) begin
      rd_count_reg <= rd_count_reg + 16'd1;
    end
  end

  assign rd_count = rd_count_reg;
`endif
endmodule
